// File: rtl/kbd_buffer_pkg.sv
// Shared definitions for the keyboard scan-code buffer: status byte bit
// positions, the IRQ state encoding and a status-byte packing helper.
package kbd_pkg;

  localparam int ST_NONEMPTY = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVF      = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } irq_state_e;

  // Packs the three flags into the port 64h style status byte.
  function automatic logic [7:0] make_status(input logic ovf,
                                             input logic full,
                                             input logic nonempty);
    logic [7:0] s;
    s              = 8'h00;
    s[ST_OVF]      = ovf;
    s[ST_FULL]     = full;
    s[ST_NONEMPTY] = nonempty;
    return s;
  endfunction

endpackage

// File: rtl/kbd_buffer_if.sv
// Signal bundle between the PS/2 receiver / port controller and the
// keyboard buffer.
//
// Handshake: there is no valid/ready pair. ps2_hit and rd are level strobes
// that the buffer edge-detects; each low-to-high transition sampled on a
// clock edge is exactly one push (ps2_data captured on that edge) or one
// pop. Holding a strobe high does nothing further. clr is a plain level
// sampled every cycle. q/status/count/irq are registered outputs and
// irq_state exposes the IRQ FSM state for observation.
interface kbd_buffer_if #(
  parameter int DEPTH_LOG2 = 4
);
  import kbd_pkg::*;

  logic [7:0]          ps2_data;
  logic                ps2_hit;
  logic                rd;
  logic                clr;
  logic                irq_en;
  logic [7:0]          q;
  logic [7:0]          status;
  logic [DEPTH_LOG2:0] count;
  logic                irq;
  irq_state_e          irq_state;

  // Buffer side.
  modport slave (
    input  ps2_data, ps2_hit, rd, clr, irq_en,
    output q, status, count, irq, irq_state
  );

  // Receiver / port controller side.
  modport master (
    output ps2_data, ps2_hit, rd, clr, irq_en,
    input  q, status, count, irq, irq_state
  );

endinterface

// File: rtl/kbd_buffer_sfifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and a
// synchronous flush. Pushes into a full FIFO are ignored unless a pop
// happens in the same cycle; pops from an empty FIFO are ignored.
module sfifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  // Accept/commit decisions and next pointer/count values.
  always_comb begin
    rd_en   = pop_i & (count_q != '0);
    wr_en   = push_i & ((count_q != FULL_CNT) | rd_en);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + AW'(1);
      if (rd_en) rptr_d = rptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only meaningful behind the count.
  always_ff @(posedge clk) begin
    if (wr_en && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

endmodule

// File: rtl/kbd_buffer.sv
// Keyboard scan-code buffer: edge-detects the receive and read strobes,
// queues bytes in an sfifo, presents registered head/status/count for the
// port controller, and raises a level IRQ with a forced low gap after every
// pop so an edge-triggered interrupt controller sees one edge per byte.
module kbd_buffer
  import kbd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_GAP    = 2
) (
  input  logic         clock,
  input  logic         reset,
  kbd_buffer_if.slave  bus
);

  localparam int CW = DEPTH_LOG2 + 1;
  // GAP state length is IRQ_GAP-1 cycles (at least one); the IDLE cycle
  // that re-arms the request completes the IRQ_GAP-cycle low interval.
  localparam int GAP_LOAD = (IRQ_GAP > 2) ? IRQ_GAP - 2 : 0;
  localparam int GAP_W    = $clog2(GAP_LOAD + 2);

  logic             hit_d_q, rd_d_q;
  logic             push, pop, pop_valid;
  logic             fifo_push, fifo_pop;
  logic [7:0]       fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty, fifo_full;
  logic             ovf_q, ovf_d;
  logic [7:0]       q_q, q_d;
  logic [7:0]       status_q, status_d;
  logic [CW-1:0]    count_q, count_d;
  irq_state_e       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             irq_q, irq_d;

  sfifo #(
    .WIDTH (8),
    .AW    (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .flush_i (bus.clr),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (bus.ps2_data),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Strobe edges, flush gating and the datapath next values.
  always_comb begin
    push      = bus.ps2_hit & ~hit_d_q;
    pop       = bus.rd & ~rd_d_q;
    fifo_push = push & ~bus.clr;
    fifo_pop  = pop & ~bus.clr;
    pop_valid = fifo_pop & ~fifo_empty;
    ovf_d     = ovf_q | (fifo_push & fifo_full & ~pop_valid);
    q_d       = fifo_empty ? 8'h00 : fifo_rdata;
    count_d   = fifo_count;
    status_d  = make_status(ovf_q, fifo_full, ~fifo_empty);
    if (bus.clr) begin
      ovf_d    = 1'b0;
      q_d      = 8'h00;
      count_d  = '0;
      status_d = 8'h00;
    end
  end

  // IRQ FSM next state; the request follows the ASSERT state.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        gap_d = '0;
        if (bus.irq_en && status_q[ST_NONEMPTY] && !bus.clr) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (bus.clr || !bus.irq_en) begin
          state_d = S_IDLE;
        end else if (pop_valid) begin
          state_d = S_GAP;
          gap_d   = GAP_W'(GAP_LOAD);
        end
      end
      S_GAP: begin
        if (bus.clr || gap_q == '0) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gap_d   = '0;
      end
    endcase
    irq_d = (state_d == S_ASSERT);
  end

  // All buffer-level registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_d_q  <= 1'b0;
      rd_d_q   <= 1'b0;
      ovf_q    <= 1'b0;
      q_q      <= 8'h00;
      status_q <= 8'h00;
      count_q  <= '0;
      state_q  <= S_IDLE;
      gap_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      hit_d_q  <= bus.ps2_hit;
      rd_d_q   <= bus.rd;
      ovf_q    <= ovf_d;
      q_q      <= q_d;
      status_q <= status_d;
      count_q  <= count_d;
      state_q  <= state_d;
      gap_q    <= gap_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.status    = status_q;
  assign bus.count     = count_q;
  assign bus.irq       = irq_q;
  assign bus.irq_state = state_q;

endmodule
